// File: rtl/tlv_uart_framer_pkg.sv
// Shared TLV type codes, framer FSM encodings and a packet-length helper.
// FSM encodings are plain constants so legacy code can compare against them directly.
package tlv_uart_framer_pkg;

  localparam logic [7:0] TLV_TYPE_SEED    = 8'd1;
  localparam logic [7:0] TLV_TYPE_PK      = 8'd2;
  localparam logic [7:0] TLV_TYPE_C0      = 8'd3;
  localparam logic [7:0] TLV_TYPE_C1      = 8'd4;
  localparam logic [7:0] TLV_TYPE_K       = 8'd5;
  localparam logic [7:0] TLV_TYPE_PROFILE = 8'd6;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HDR_TYPE = 3'd1;
  localparam logic [2:0] S_HDR_LEN  = 3'd2;
  localparam logic [2:0] S_TX_WAIT  = 3'd3;
  localparam logic [2:0] S_FETCH    = 3'd4;
  localparam logic [2:0] S_MEM_WAIT = 3'd5;
  localparam logic [2:0] S_VAL      = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  // Bytes carried by the next packet: the remaining count clipped to the packet limit.
  function automatic logic [7:0] clip_len(input logic [31:0] remaining, input logic [31:0] max_len);
    logic [31:0] len;
    len = (remaining > max_len) ? max_len : remaining;
    return len[7:0];
  endfunction

endpackage

// File: rtl/tlv_uart_framer.sv
// TLV transmit framer: streams a RAM buffer to the UART transmitter as
// [TYPE][LENGTH][VALUE x LENGTH] packets, little-endian within each 32-bit word.
module tlv_uart_framer
  import tlv_uart_framer_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_LEN    = 16,
  parameter int TOT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            frame_type,
  input  logic [TOT_WIDTH-1:0]  total_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_q,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_done
);

  logic [2:0]            state_reg;
  logic [2:0]            ret_reg;
  logic [7:0]            type_reg;
  logic [TOT_WIDTH-1:0]  remaining_reg;
  logic [TOT_WIDTH-1:0]  byte_idx_reg;
  logic [7:0]            pkt_cnt_reg;
  logic [ADDR_WIDTH-1:0] word_idx_reg;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic                  load_reg;

  logic [7:0]            pkt_len;
  logic [TOT_WIDTH-1:0]  byte_idx_next;

  always_comb begin
    pkt_len       = clip_len(32'(remaining_reg), 32'(MAX_LEN));
    byte_idx_next = byte_idx_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      ret_reg       <= S_IDLE;
      type_reg      <= '0;
      remaining_reg <= '0;
      byte_idx_reg  <= '0;
      pkt_cnt_reg   <= '0;
      word_idx_reg  <= '0;
      shift_reg     <= '0;
      load_reg      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      mem_rd        <= 1'b0;
      mem_addr      <= '0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
    end else begin
      tx_start <= 1'b0;
      mem_rd   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (frame_type != 8'd0 && total_bytes != '0) begin
              type_reg      <= frame_type;
              remaining_reg <= total_bytes;
              byte_idx_reg  <= '0;
              word_idx_reg  <= '0;
              pkt_cnt_reg   <= '0;
              load_reg      <= 1'b0;
              busy          <= 1'b1;
              state_reg     <= S_HDR_TYPE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_HDR_TYPE: begin
          tx_data   <= type_reg;
          tx_start  <= 1'b1;
          ret_reg   <= S_HDR_LEN;
          state_reg <= S_TX_WAIT;
        end
        S_HDR_LEN: begin
          tx_data       <= pkt_len;
          tx_start      <= 1'b1;
          pkt_cnt_reg   <= pkt_len;
          remaining_reg <= remaining_reg - TOT_WIDTH'(pkt_len);
          // A packet may begin mid-word; only fetch when sitting on a word boundary.
          ret_reg       <= (byte_idx_reg[1:0] == 2'd0) ? S_FETCH : S_VAL;
          state_reg     <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (tx_done) begin
            if (ret_reg == S_DONE) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
            state_reg <= ret_reg;
          end
        end
        S_FETCH: begin
          mem_rd    <= 1'b1;
          mem_addr  <= word_idx_reg;
          state_reg <= S_MEM_WAIT;
        end
        S_MEM_WAIT: begin
          load_reg  <= 1'b1;
          state_reg <= S_VAL;
        end
        S_VAL: begin
          if (load_reg) begin
            tx_data      <= mem_q[7:0];
            shift_reg    <= mem_q >> 8;
            word_idx_reg <= word_idx_reg + 1'b1;
            load_reg     <= 1'b0;
          end else begin
            tx_data   <= shift_reg[7:0];
            shift_reg <= shift_reg >> 8;
          end
          tx_start     <= 1'b1;
          byte_idx_reg <= byte_idx_next;
          pkt_cnt_reg  <= pkt_cnt_reg - 8'd1;
          if (pkt_cnt_reg == 8'd1)
            ret_reg <= (remaining_reg == '0) ? S_DONE : S_HDR_TYPE;
          else
            ret_reg <= (byte_idx_next[1:0] == 2'd0) ? S_FETCH : S_VAL;
          state_reg <= S_TX_WAIT;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlv_uart_framer.sv
// Scoreboard bench: stimulus pushes expected bytes/addresses, a monitor pops and compares.
// Instance a uses a 16-word RAM window, instance b a 4-word window for address wrap.
module tb_tlv_uart_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [7:0]  frame_type = 8'd0;
  logic [15:0] total_bytes = 16'd0;
  logic        tx_done = 1'b0;

  logic        busy_a, done_a, err_a, mem_rd_a, tx_start_a;
  logic [3:0]  mem_addr_a;
  logic [7:0]  tx_data_a;
  logic [31:0] mem_q_a = 32'd0;
  logic        busy_b, done_b, err_b, mem_rd_b, tx_start_b;
  logic [1:0]  mem_addr_b;
  logic [7:0]  tx_data_b;
  logic [31:0] mem_q_b = 32'd0;

  logic [31:0] ram [0:15];

  int total = 0;
  int bad = 0;

  logic [7:0] exp_bytes[$];
  logic [3:0] exp_addr[$];
  int done_seen = 0;
  int err_seen = 0;

  bit         tx_active = 1'b0;
  bit         tx_abort = 1'b0;
  bit         tx_sel = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] tx_held = 8'd0;

  tlv_uart_framer #(.WORD_WIDTH(32), .ADDR_WIDTH(4), .MAX_LEN(16), .TOT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .frame_type(frame_type), .total_bytes(total_bytes),
    .busy(busy_a), .done(done_a), .err(err_a), .mem_rd(mem_rd_a), .mem_addr(mem_addr_a),
    .mem_q(mem_q_a), .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_done(tx_done)
  );

  tlv_uart_framer #(.WORD_WIDTH(32), .ADDR_WIDTH(2), .MAX_LEN(16), .TOT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .frame_type(frame_type), .total_bytes(total_bytes),
    .busy(busy_b), .done(done_b), .err(err_b), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b),
    .mem_q(mem_q_b), .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle registered read per instance.
  always @(posedge clk) begin
    if (mem_rd_a) mem_q_a <= ram[mem_addr_a];
    if (mem_rd_b) mem_q_b <= ram[{2'b00, mem_addr_b}];
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor plus transmitter model (tx_done 10 cycles after tx_start).
  initial begin
    logic [7:0] cur;
    logic [7:0] e;
    logic [3:0] a;
    forever begin
      @(negedge clk);
      if (tx_done) tx_done = 1'b0;
      if (tx_active) begin
        if (rst) tx_abort = 1'b1;
        cur = tx_sel ? tx_data_b : tx_data_a;
        if (!tx_abort) check(cur == tx_held, "tx_data_stable", cur, tx_held);
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done = 1'b1;
          tx_active = 1'b0;
        end
      end
      if (tx_start_a || tx_start_b) begin
        cur = tx_start_b ? tx_data_b : tx_data_a;
        check(!tx_active, "tx_start_while_active", 32'(tx_active), 0);
        check(exp_bytes.size() != 0, "unexpected_tx_byte", cur, 0);
        if (exp_bytes.size() != 0) begin
          e = exp_bytes.pop_front();
          check(cur == e, "tx_byte", cur, e);
        end
        tx_active = 1'b1;
        tx_abort = 1'b0;
        tx_sel = tx_start_b;
        tx_cnt = 10;
        tx_held = cur;
      end
      if (mem_rd_a || mem_rd_b) begin
        a = mem_rd_b ? {2'b00, mem_addr_b} : mem_addr_a;
        check(exp_addr.size() != 0, "unexpected_mem_rd", a, 0);
        if (exp_addr.size() != 0) begin
          e = {4'd0, exp_addr.pop_front()};
          check(a == e[3:0], "mem_addr", a, e);
        end
      end
      if (done_a || done_b) done_seen++;
      if (err_a || err_b) err_seen++;
    end
  end

  // Reference packetiser used for the longer frames.
  task automatic model_push(input int aw, input logic [7:0] typ, input int tot);
    int rem;
    int idx;
    int len;
    logic [31:0] w;
    rem = tot;
    idx = 0;
    while (rem > 0) begin
      len = (rem > 16) ? 16 : rem;
      exp_bytes.push_back(typ);
      exp_bytes.push_back(8'(len));
      for (int k = 0; k < len; k++) begin
        w = ram[(idx / 4) % (1 << aw)];
        exp_bytes.push_back(w[8 * (idx % 4) +: 8]);
        idx++;
      end
      rem -= len;
    end
  endtask

  task automatic push_addrs(input int aw, input int tot);
    for (int i = 0; i < (tot + 3) / 4; i++) exp_addr.push_back(4'(i % (1 << aw)));
  endtask

  task automatic run_frame(input bit sel, input logic [7:0] typ, input logic [15:0] tot, input bit poke_busy);
    int d0;
    int e0;
    int cycles;
    d0 = done_seen;
    e0 = err_seen;
    @(negedge clk);
    frame_type = typ;
    total_bytes = tot;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    frame_type = 8'($urandom);
    total_bytes = 16'($urandom);
    check((sel ? busy_b : busy_a) == 1'b1, "busy_after_start", 32'(sel ? busy_b : busy_a), 1);
    check((sel ? tx_start_b : tx_start_a) == 1'b0, "tx_start_early", 32'(sel ? tx_start_b : tx_start_a), 0);
    @(negedge clk);
    check((sel ? tx_start_b : tx_start_a) == 1'b1, "start_latency", 32'(sel ? tx_start_b : tx_start_a), 1);
    if (poke_busy) begin
      repeat (5) @(negedge clk);
      frame_type = 8'd9;
      total_bytes = 16'd1;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      frame_type = 8'd0;
      total_bytes = 16'd0;
    end
    cycles = 0;
    while (done_seen == d0 && cycles < 5000) begin
      @(negedge clk);
      cycles++;
    end
    check(cycles < 5000, "done_timeout", cycles, 5000);
    repeat (3) @(negedge clk);
    check(done_seen == d0 + 1, "done_once", done_seen - d0, 1);
    check(err_seen == e0, "no_err", err_seen - e0, 0);
    check(exp_bytes.size() == 0, "bytes_left", exp_bytes.size(), 0);
    check(exp_addr.size() == 0, "addrs_left", exp_addr.size(), 0);
    check((sel ? busy_b : busy_a) == 1'b0, "busy_after_done", 32'(sel ? busy_b : busy_a), 0);
  endtask

  task automatic bad_start(input logic [7:0] typ, input logic [15:0] tot);
    @(negedge clk);
    frame_type = typ;
    total_bytes = tot;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check(err_a == 1'b1, "err_pulse", 32'(err_a), 1);
    check(busy_a == 1'b0, "err_busy", 32'(busy_a), 0);
    @(negedge clk);
    check(err_a == 1'b0, "err_one_cycle", 32'(err_a), 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [7:0] hand1 [10];
    logic [7:0] hand2 [8];
    int seen;
    hand1 = '{8'h05, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    hand2 = '{8'h03, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ram[0] = 32'h44332211;
    ram[1] = 32'h88776655;
    for (int i = 2; i < 16; i++) ram[i] = {8'(i + 8'h30), 8'(i + 8'h20), 8'(i + 8'h10), 8'(i)};

    repeat (3) @(negedge clk);
    check({busy_a, done_a, err_a, mem_rd_a, tx_start_a} == 5'd0, "reset_flags",
          {busy_a, done_a, err_a, mem_rd_a, tx_start_a}, 0);
    check({mem_addr_a, tx_data_a} == 12'd0, "reset_addr_data", {mem_addr_a, tx_data_a}, 0);
    rst = 1'b0;

    foreach (hand1[i]) exp_bytes.push_back(hand1[i]);
    push_addrs(4, 8);
    run_frame(1'b0, 8'd5, 16'd8, 1'b0);

    foreach (hand2[i]) exp_bytes.push_back(hand2[i]);
    push_addrs(4, 6);
    run_frame(1'b0, 8'd3, 16'd6, 1'b0);

    model_push(4, 8'd4, 20);
    push_addrs(4, 20);
    run_frame(1'b0, 8'd4, 16'd20, 1'b1);

    bad_start(8'd0, 16'd5);
    bad_start(8'd2, 16'd0);

    model_push(2, 8'd6, 20);
    push_addrs(2, 20);
    run_frame(1'b1, 8'd6, 16'd20, 1'b0);

    // Abort a frame right after its third byte completes.
    model_push(4, 8'd3, 20);
    push_addrs(4, 20);
    @(negedge clk);
    frame_type = 8'd3;
    total_bytes = 16'd20;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    seen = 0;
    for (int c = 0; c < 500 && seen < 3; c++) begin
      @(posedge clk);
      if (tx_done) seen++;
    end
    check(seen == 3, "third_tx_done", seen, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({busy_a, done_a, err_a, mem_rd_a, tx_start_a} == 5'd0, "midframe_reset_flags",
          {busy_a, done_a, err_a, mem_rd_a, tx_start_a}, 0);
    check({mem_addr_a, tx_data_a} == 12'd0, "midframe_reset_addr_data", {mem_addr_a, tx_data_a}, 0);
    rst = 1'b0;
    exp_bytes.delete();
    exp_addr.delete();
    repeat (15) @(negedge clk);

    model_push(4, 8'd2, 37);
    push_addrs(4, 37);
    run_frame(1'b0, 8'd2, 16'd37, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
